// File: rtl/exec_dispatch.sv
// exec_dispatch: routes decoded instrs to functional units by opcode with per-unit credits, buffers unit results in per-unit FIFOs and drains them round-robin onto one backpressurable result port.
// Ports: clk/rst (sync, active-low), flush; in_valid/in_ready/in_op/in_data from decode;
// fu_valid/fu_ready/fu_data/fu_flush issue side; fu_res_valid/fu_res_data unit results;
// out_valid/out_ready/out_data/out_unit result port.
// Optional EXEC_DISPATCH_STATS_EN adds stat_issued/stat_stall_fu/stat_stall_out counters.
module exec_dispatch #(
  parameter int NUM_UNITS = 4,
  parameter int OP_W      = 5,
  parameter int INSTR_W   = 128,
  parameter int RESULT_W  = 96,
  parameter int RES_DEPTH = 2,
  parameter logic [NUM_UNITS*(2**OP_W)-1:0] UNIT_OP_MAP = '1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [OP_W-1:0]                   in_op,
  input  logic [INSTR_W-1:0]                in_data,
  output logic [NUM_UNITS-1:0]              fu_valid,
  input  logic [NUM_UNITS-1:0]              fu_ready,
  output logic [INSTR_W-1:0]                fu_data,
  output logic                              fu_flush,
  input  logic [NUM_UNITS-1:0]              fu_res_valid,
  input  logic [NUM_UNITS*RESULT_W-1:0]     fu_res_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [RESULT_W-1:0]               out_data,
`ifdef EXEC_DISPATCH_STATS_EN
  output logic [31:0]                       stat_issued,
  output logic [31:0]                       stat_stall_fu,
  output logic [31:0]                       stat_stall_out,
`endif
  output logic [$clog2(NUM_UNITS)-1:0]      out_unit
);
  localparam int UW  = $clog2(NUM_UNITS);
  localparam int CW  = $clog2(RES_DEPTH + 1);
  localparam int PW  = RES_DEPTH > 1 ? $clog2(RES_DEPTH) : 1;
  localparam int NOP = 2 ** OP_W;
  localparam logic [NUM_UNITS-1:0] ONE = {{(NUM_UNITS-1){1'b0}}, 1'b1};
  logic [UW-1:0] sel, gnt, gnt_q, rr;
  logic hold, pop_en;
  logic [CW-1:0] cnt [NUM_UNITS];
  logic [CW-1:0] occ [NUM_UNITS];
  logic [PW-1:0] rp [NUM_UNITS];
  logic [PW-1:0] wp [NUM_UNITS];
  logic [RESULT_W-1:0] mem [NUM_UNITS][RES_DEPTH];
  logic [NUM_UNITS-1:0] cand, push, pop;
  always_comb begin
    sel = '0;
    for (int u = NUM_UNITS - 1; u >= 0; u--)
      if (UNIT_OP_MAP[u*NOP + int'(in_op)]) sel = UW'(u);
  end
  assign in_ready = rst & fu_ready[sel] & (cnt[sel] < CW'(RES_DEPTH)) & ~flush;
  assign fu_valid = (in_valid && in_ready) ? ONE << sel : '0;
  assign fu_data  = in_data;
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) cand[u] = occ[u] != '0;
  end
  // A stalled grant stays latched so a newcomer closer to rr cannot steal the port.
  always_comb begin
    gnt = gnt_q;
    if (!hold)
      for (int i = NUM_UNITS - 1; i >= 0; i--)
        if (cand[(int'(rr) + i) % NUM_UNITS]) gnt = UW'((int'(rr) + i) % NUM_UNITS);
  end
  assign out_valid = rst & |cand;
  assign out_data  = mem[gnt][rp[gnt]];
  assign out_unit  = gnt;
  assign pop_en    = out_valid & out_ready & ~flush;
  assign pop       = pop_en ? ONE << gnt : '0;
  assign push      = fu_res_valid & {NUM_UNITS{~flush}};
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        cnt[u] <= '0;
        occ[u] <= '0;
        rp[u]  <= '0;
        wp[u]  <= '0;
      end
      hold  <= 1'b0;
      gnt_q <= '0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        cnt[u] <= cnt[u] + CW'(fu_valid[u]) - CW'(pop[u]);
        occ[u] <= occ[u] + CW'(push[u]) - CW'(pop[u]);
        if (push[u]) wp[u] <= wp[u] == PW'(RES_DEPTH - 1) ? '0 : wp[u] + 1'b1;
        if (pop[u]) rp[u] <= rp[u] == PW'(RES_DEPTH - 1) ? '0 : rp[u] + 1'b1;
      end
      hold  <= out_valid & ~out_ready;
      gnt_q <= gnt;
    end
  end
  always_ff @(posedge clk) begin
    for (int u = 0; u < NUM_UNITS; u++)
      if (push[u]) mem[u][wp[u]] <= fu_res_data[u*RESULT_W +: RESULT_W];
  end
  always_ff @(posedge clk) begin
    if (!rst) rr <= '0;
    else if (pop_en) rr <= gnt == UW'(NUM_UNITS - 1) ? '0 : gnt + 1'b1;
    fu_flush <= rst & flush;
  end
  // Credits bound occupancy, so a push into a full FIFO without a same-cycle pop is a unit bug.
  always_ff @(posedge clk) begin
    if (rst && !flush)
      for (int u = 0; u < NUM_UNITS; u++)
        assert (!(push[u] && !pop[u] && occ[u] == CW'(RES_DEPTH)));
  end
`ifdef EXEC_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_issued    <= '0;
      stat_stall_fu  <= '0;
      stat_stall_out <= '0;
    end else begin
      if (|fu_valid) stat_issued <= stat_issued + 1'b1;
      if (in_valid && !in_ready && !flush) stat_stall_fu <= stat_stall_fu + 1'b1;
      if (out_valid && !out_ready) stat_stall_out <= stat_stall_out + 1'b1;
    end
  end
`endif
endmodule
